cost_ctrl: RTL and testbench
============================

COST_CTRL -- requirements
Module: cost_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: fixed-point data width of deltas, threshold and cost.
REQ-002 Parameter FRAC, default 24: fractional bits of all fixed-point values.
REQ-003 Parameter NSAMPLE, default 4: samples per batch; legal range 1..2^16-1.
REQ-004 Parameter EPW, default 16: epoch counter width.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
REQ-007 start  in  1  one-cycle pulse that begins a batch.
REQ-008 abort  in  1  cancels the batch in progress.
REQ-009 i_valid  in  1  the sample on i_d1/i_d2 is valid.
REQ-010 i_ready  out  1  the block accepts a sample this cycle.
REQ-011 i_d1, i_d2  in  WIDTH  signed output-layer errors of one sample.
REQ-012 thresh  in  WIDTH  signed convergence threshold, sampled in the DONE state.
REQ-013 o_cost  out  WIDTH  signed batch cost, held until the next batch completes.
REQ-014 o_done  out  1  one-cycle pulse when o_cost updates.
REQ-015 o_conv  out  1  o_cost < thresh, registered with o_cost.
REQ-016 o_busy  out  1  high in the ACC state.
REQ-017 o_epoch  out  EPW  count of completed batches.

Function
REQ-018 The FSM SHALL have the states IDLE, ACC and DONE.
REQ-019 IDLE: i_ready=0; start SHALL clear the accumulator and the sample counter and move to ACC.
REQ-020 ACC: i_ready=1; an accept is i_valid&&i_ready; each accept adds term(i_d1,i_d2) to the accumulator and increments the counter.
REQ-021 The accept that makes the counter equal NSAMPLE SHALL move the FSM to DONE on the next edge.
REQ-022 DONE (one cycle): o_cost<=accumulator, o_conv<=(accumulator<thresh), o_done=1, o_epoch increments, then the FSM returns to IDLE.
REQ-023 Latency: o_done SHALL be high exactly 1 cycle after the last accepted sample; o_cost/o_conv SHALL be valid from that cycle.
REQ-024 term = (sq(d1)+sq(d2)) >>> 1 (arithmetic shift); sq(x) = full 2*WIDTH product x*x, then bits [WIDTH+FRAC-1:FRAC] kept.
REQ-025 The accumulator add SHALL saturate at 2^(WIDTH-1)-1; once saturated it stays saturated until cleared.
REQ-026 start in ACC or DONE SHALL be ignored.
REQ-027 abort in ACC SHALL return the FSM to IDLE with no o_done pulse; o_cost, o_conv and o_epoch are unchanged.
REQ-028 If abort and the final accept occur in the same cycle, abort wins and the sample is discarded.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 o_epoch SHALL wrap from 2^EPW-1 to 0.
REQ-031 i_valid without i_ready SHALL not change state; i_d1 and i_d2 are don't-care when i_valid is low.

Reset
REQ-032 Reset SHALL set the state to IDLE and clear the accumulator, counter, o_cost and o_epoch to 0.
REQ-033 Reset SHALL drive o_conv, o_done, o_busy and i_ready to 0.
REQ-034 Reset asserted mid-batch SHALL discard the partial sum; no o_done pulse follows reset release.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the saturation constant and the fixed-point ONE constant (1<<FRAC).
REQ-036 The squared-error term SHALL be one combinational sub-module, cost_term (inputs i_d1, i_d2; output term; parameters WIDTH, FRAC).
REQ-037 The sample counter SHALL be 16 bits.
REQ-038 The FSM, counter, accumulator and output registers SHALL live in cost_ctrl.

Verification (FRAC=24, 1.0 = 0x0100_0000)
REQ-039 NSAMPLE=4; four accepts with d1=d2=0x0100_0000 -> o_cost=0x0400_0000, o_done 1 cycle after the 4th accept; with thresh=0x0500_0000 -> o_conv=1, o_epoch=1.
REQ-040 d1=0x0080_0000 (0.5), d2=0 for 4 samples -> term=0x0020_0000, o_cost=0x0080_0000; with thresh=0x0080_0000 -> o_conv=0.
REQ-041 i_valid toggled with bubbles during ACC -> only accepted samples counted; o_cost unchanged by idle cycles.
REQ-042 abort after 2 accepts -> no o_done, previous o_cost and o_epoch held; the next start plus 4 accepts gives a correct fresh sum.
REQ-043 d1=d2=0x7FFF_FFFF repeated -> o_cost=0x7FFF_FFFF (saturated); start pulses during ACC are ignored.
REQ-044 rst driven low after 3 accepts -> all outputs 0 immediately; after release the block stays in IDLE with no o_done.

Source files
------------

// File: rtl/cost_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cost_ctrl_pkg
//  Description : Shared constants for the batch cost controller: FSM state
//                encoding, fixed-point ONE, accumulator saturation value.
//  Revision    : 1.0  initial release
// ============================================================================
package cost_ctrl_pkg;

    localparam int C_DEF_WIDTH = 32;
    localparam int C_DEF_FRAC  = 24;
    localparam int C_CNT_W     = 16;

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Largest positive value of a 64-bit signed word; a WIDTH-bit user shifts
    // it right by (64-WIDTH) to get 2^(WIDTH-1)-1.
    localparam logic [63:0] C_SAT_64 = 64'h7FFF_FFFF_FFFF_FFFF;

    // Fixed-point 1.0 for a given number of fractional bits
    function automatic logic [63:0] fx_one(input int frac);
        return 64'd1 << frac;
    endfunction

    localparam logic [63:0] C_ONE = fx_one(C_DEF_FRAC);

endpackage
`default_nettype wire

// File: rtl/cost_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cost_ctrl_if
//  Description : Sample stream (valid/ready plus two error words) feeding the
//                cost controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface cost_ctrl_if
    import cost_ctrl_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
);
    logic                    i_valid;
    logic                    i_ready;
    logic signed [WIDTH-1:0] i_d1;
    logic signed [WIDTH-1:0] i_d2;

    modport master (output i_valid, output i_d1, output i_d2, input  i_ready);
    modport slave  (input  i_valid, input  i_d1, input  i_d2, output i_ready);
endinterface
`default_nettype wire

// File: rtl/cost_term.sv
`default_nettype none
// ============================================================================
//  Module      : cost_term
//  Description : Half sum of squared errors, (sq(d1)+sq(d2)) >> 1, where sq
//                keeps bits [WIDTH+FRAC-1:FRAC] of the full product.
//  Revision    : 1.0  initial release
// ============================================================================
module cost_term
    import cost_ctrl_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int FRAC  = C_DEF_FRAC
) (
    input  logic signed [WIDTH-1:0] i_d1,
    input  logic signed [WIDTH-1:0] i_d2,
    output logic        [WIDTH-1:0] term
);
    logic signed [2*WIDTH-1:0] w_p1, w_p2;
    logic        [2*WIDTH-1:0] w_s1, w_s2;
    logic        [WIDTH:0]     w_sum;
    logic                      w_unused;

    assign w_p1 = i_d1 * i_d1;
    assign w_p2 = i_d2 * i_d2;
    assign w_s1 = w_p1 >> FRAC;
    assign w_s2 = w_p2 >> FRAC;

    // The kept square slices are magnitudes; adding them one bit wider keeps
    // the carry, so the halved result is never negative and fits WIDTH bits.
    assign w_sum = {1'b0, w_s1[WIDTH-1:0]} + {1'b0, w_s2[WIDTH-1:0]};
    assign term  = w_sum[WIDTH:1];

    assign w_unused = ^{w_s1[2*WIDTH-1:WIDTH], w_s2[2*WIDTH-1:WIDTH], w_sum[0]};
endmodule
`default_nettype wire

// File: rtl/cost_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cost_ctrl
//  Description : Accumulates a saturating batch cost over NSAMPLE accepted
//                samples, then publishes cost, convergence flag and epoch.
//  Revision    : 1.0  initial release
// ============================================================================
module cost_ctrl
    import cost_ctrl_pkg::*;
#(
    parameter int WIDTH   = C_DEF_WIDTH,
    parameter int FRAC    = C_DEF_FRAC,
    parameter int NSAMPLE = 4,
    parameter int EPW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    cost_ctrl_if.slave              s_if,
    input  logic signed [WIDTH-1:0] thresh,
    output logic signed [WIDTH-1:0] o_cost,
    output logic                    o_done,
    output logic                    o_conv,
    output logic                    o_busy,
    output logic [EPW-1:0]          o_epoch
);
    localparam logic [WIDTH-1:0]   c_SAT      = WIDTH'(C_SAT_64 >> (64 - WIDTH));
    localparam logic [C_CNT_W-1:0] c_NSAMPLE  = C_CNT_W'(NSAMPLE);

    logic [1:0]              state_q, state_d;
    logic [WIDTH-1:0]        acc_q,   acc_d;
    logic [C_CNT_W-1:0]      cnt_q,   cnt_d;
    logic signed [WIDTH-1:0] cost_q,  cost_d;
    logic                    conv_q,  conv_d;
    logic                    done_q,  done_d;
    logic [EPW-1:0]          epoch_q, epoch_d;

    logic [WIDTH-1:0]        w_term;
    logic [WIDTH:0]          w_sum;

    cost_term #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_term (
        .i_d1  (s_if.i_d1),
        .i_d2  (s_if.i_d2),
        .term  (w_term)
    );

    // Both operands are non-negative, so one extra bit catches any overflow
    assign w_sum = {1'b0, acc_q} + {1'b0, w_term};

    // Next-state logic: batch sequencing, saturating accumulate, result capture
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cost_d  = cost_q;
        conv_d  = conv_q;
        done_d  = 1'b0;
        epoch_d = epoch_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                // abort takes priority, even over the final sample
                if (abort) begin
                    state_d = S_IDLE;
                end else if (s_if.i_valid) begin
                    acc_d = (w_sum > {1'b0, c_SAT}) ? c_SAT : w_sum[WIDTH-1:0];
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == c_NSAMPLE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cost_d  = acc_q;
                conv_d  = ($signed(acc_q) < thresh);
                done_d  = 1'b1;
                epoch_d = epoch_q + EPW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            cost_q  <= '0;
            conv_q  <= 1'b0;
            done_q  <= 1'b0;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            cost_q  <= cost_d;
            conv_q  <= conv_d;
            done_q  <= done_d;
            epoch_q <= epoch_d;
        end
    end

    assign s_if.i_ready = (state_q == S_ACC);
    assign o_busy       = (state_q == S_ACC);
    assign o_cost       = cost_q;
    assign o_conv       = conv_q;
    assign o_done       = done_q;
    assign o_epoch      = epoch_q;
endmodule
`default_nettype wire

// File: tb/tb_cost_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cost_ctrl
//  Description : Directed self-checking bench for cost_ctrl with a reference
//                model and a result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cost_ctrl;
    import cost_ctrl_pkg::*;

    localparam int W  = 32;
    localparam int F  = 24;
    localparam int NS = 4;
    localparam int EW = 3;
    localparam logic [31:0] c_ONE  = 32'(C_ONE);
    localparam logic [31:0] c_MONE = 32'hFF00_0000;
    localparam logic [31:0] c_HALF = 32'h0080_0000;
    localparam logic [31:0] c_MAXP = 32'h7FFF_FFFF;

    logic                clk    = 1'b0;
    logic                rst    = 1'b0;
    logic                start  = 1'b0;
    logic                abort  = 1'b0;
    logic signed [W-1:0] thresh = '0;
    logic [W-1:0]        o_cost;
    logic                o_done, o_conv, o_busy;
    logic [EW-1:0]       o_epoch;

    cost_ctrl_if #(.WIDTH(W)) bus ();

    cost_ctrl #(.WIDTH(W), .FRAC(F), .NSAMPLE(NS), .EPW(EW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .s_if    (bus),
        .thresh  (thresh),
        .o_cost  (o_cost),
        .o_done  (o_done),
        .o_conv  (o_conv),
        .o_busy  (o_busy),
        .o_epoch (o_epoch)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;
    int m_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   cost;
        logic          conv;
        logic [EW-1:0] epoch;
        int            cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // reference model state
    logic [31:0]   m_acc   = '0;
    logic [31:0]   m_cost  = '0;
    logic [EW-1:0] m_epoch = '0;
    int            m_cnt   = 0;
    bit            m_active = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_term(input logic [31:0] a, input logic [31:0] b);
        longint      pa, pb;
        logic [63:0] sa, sbb;
        pa  = longint'($signed(a)) * longint'($signed(a));
        pb  = longint'($signed(b)) * longint'($signed(b));
        sa  = (64'(pa) >> F) & 64'hFFFF_FFFF;
        sbb = (64'(pb) >> F) & 64'hFFFF_FFFF;
        return 32'((sa + sbb) >> 1);
    endfunction

    // scoreboard consumer: every o_done pulse must match a pending result
    always @(negedge clk) begin
        if (rst && o_done) begin
            n_done++;
            chk("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("cost",         64'(o_cost),  64'(mon_e.cost));
                chk("conv",         64'(o_conv),  64'(mon_e.conv));
                chk("epoch",        64'(o_epoch), 64'(mon_e.epoch));
                chk("done_latency", 64'(cyc),     64'(mon_e.cyc));
            end
        end
    end

    task automatic sample(input logic [31:0] a, input logic [31:0] b,
                          input bit ab = 1'b0, input bit st = 1'b0);
        logic [63:0] s;
        @(negedge clk);
        chk("i_ready", 64'(bus.i_ready), 64'(m_active));
        bus.i_valid = 1'b1; bus.i_d1 = a; bus.i_d2 = b;
        abort = ab; start = st;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_d1 = $urandom; bus.i_d2 = $urandom;
        abort = 1'b0; start = 1'b0;
        if (m_active && ab) begin
            m_active = 1'b0;
        end else if (m_active) begin
            s     = {32'd0, m_acc} + {32'd0, m_term(a, b)};
            m_acc = (s > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : s[31:0];
            m_cnt++;
            if (m_cnt == NS) begin
                m_active = 1'b0;
                m_epoch  = m_epoch + 1'b1;
                m_cost   = m_acc;
                m_done++;
                sb.push_back('{cost: m_acc, conv: ($signed(m_acc) < thresh),
                               epoch: m_epoch, cyc: cyc + 1});
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        if (!m_active) begin m_active = 1'b1; m_acc = '0; m_cnt = 0; end
    endtask

    task automatic do_abort();
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_valid = 1'b0; bus.i_d1 = $urandom; bus.i_d2 = $urandom;
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 8) begin @(negedge clk); k++; end
        #1;
        chk("done_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic batch(input logic [31:0] a, input logic [31:0] b);
        do_start();
        chk("busy_after_start", 64'(o_busy), 64'd1);
        for (int i = 0; i < NS; i++) sample(a, b);
        wait_done();
        chk("cost_hold", 64'(o_cost), 64'(m_cost));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_valid = 1'b0; bus.i_d1 = '0; bus.i_d2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cost",  64'(o_cost),    64'd0);
        chk("rst_done",  64'(o_done),    64'd0);
        chk("rst_conv",  64'(o_conv),    64'd0);
        chk("rst_busy",  64'(o_busy),    64'd0);
        chk("rst_ready", 64'(bus.i_ready), 64'd0);
        chk("rst_epoch", 64'(o_epoch),   64'd0);
        rst = 1'b1;

        // valid while idle is ignored; abort while idle too
        sample(c_ONE, c_ONE);
        do_abort();
        chk("idle_busy", 64'(o_busy), 64'd0);

        // 4 x (1.0,1.0) -> 4.0, below 5.0
        thresh = 32'sh0500_0000;
        batch(c_ONE, c_ONE);

        // 4 x (0.5,0) -> 0.5, not below 0.5
        thresh = 32'sh0080_0000;
        batch(c_HALF, 32'd0);

        // bubbles and negative inputs; 4 x 0.625 = 2.5 just below threshold
        thresh = 32'sh0280_0001;
        do_start();
        sample(c_ONE, c_HALF);
        bubble(2);
        chk("cost_hold_bubble", 64'(o_cost), 64'(m_cost));
        sample(c_MONE, c_HALF);
        bubble(1);
        sample(c_HALF, c_MONE);
        bubble(3);
        sample(c_ONE, 32'hFF80_0000);
        wait_done();

        // abort after two accepts: nothing published, then a fresh batch
        thresh = 32'sh0300_0000;
        do_start();
        sample(c_ONE, c_ONE);
        sample(c_ONE, c_ONE);
        do_abort();
        bubble(3);
        chk("abort_busy",  64'(o_busy),  64'd0);
        chk("abort_cost",  64'(o_cost),  64'(m_cost));
        chk("abort_epoch", 64'(o_epoch), 64'(m_epoch));
        chk("abort_ndone", 64'(n_done),  64'(m_done));
        batch(c_ONE, c_ONE);

        // abort in the same cycle as the final accept discards the batch
        do_start();
        for (int i = 0; i < NS - 1; i++) sample(c_HALF, c_HALF);
        sample(c_HALF, c_HALF, 1'b1);
        bubble(3);
        chk("abort_last_busy",  64'(o_busy),  64'd0);
        chk("abort_last_epoch", 64'(o_epoch), 64'(m_epoch));
        chk("abort_last_ndone", 64'(n_done),  64'(m_done));

        // saturation; start during ACC and start/abort during DONE ignored
        thresh = 32'sh7FFF_FFFF;
        do_start();
        sample(c_MAXP, c_MAXP);
        sample(c_MAXP, c_MAXP, 1'b0, 1'b1);
        sample(c_MAXP, c_MAXP);
        sample(c_MAXP, c_MAXP);
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        wait_done();
        chk("sat_cost",       64'(o_cost), 64'h7FFF_FFFF);
        chk("busy_after_done", 64'(o_busy), 64'd0);

        // asynchronous reset mid-batch
        do_start();
        for (int i = 0; i < 3; i++) sample(c_ONE, c_ONE);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_cost",  64'(o_cost),  64'd0);
        chk("arst_done",  64'(o_done),  64'd0);
        chk("arst_conv",  64'(o_conv),  64'd0);
        chk("arst_busy",  64'(o_busy),  64'd0);
        chk("arst_ready", 64'(bus.i_ready), 64'd0);
        chk("arst_epoch", 64'(o_epoch), 64'd0);
        m_active = 1'b0; m_cost = '0; m_epoch = '0; sb.delete();
        @(negedge clk); rst = 1'b1;
        bubble(4);
        chk("post_rst_busy",  64'(o_busy), 64'd0);
        chk("post_rst_ndone", 64'(n_done), 64'(m_done));

        // epoch wraps after 2^EW batches
        thresh = 32'sh0100_0000;
        for (int b = 0; b < 9; b++) batch(32'd0, 32'd0);
        chk("epoch_wrap", 64'(o_epoch), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
